// File: rtl/led_tick_counter.sv
// led_tick_counter
//   Prescaled modulo counter for one LED/digit field. A prescaler divides the
//   board clock down to a periodic tick. Each tick moves the count up or down
//   modulo MODULUS. With ONE_SHOT=1 the count instead stops at the terminal
//   value. tc marks the wrap or terminal event so that a higher digit can be
//   cascaded from it.
//
// Ports
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-high reset
//   start    in   enter RUNNING (from DONE also reloads the count)
//   stop     in   enter STOPPED, count held
//   up_dn    in   1 = count up, 0 = count down, sampled on each tick
//   load     in   synchronous load of load_val (clamped to MODULUS-1)
//   load_val in   [WIDTH] load value
//   count    out  [WIDTH] current count
//   tick     out  one-cycle pulse per prescale period while RUNNING
//   tc       out  one-cycle pulse on wrap / terminal value
//   running  out  state is RUNNING
//   done     out  state is DONE (one-shot only)
module led_tick_counter #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             running,
    output logic             done
);

    localparam int unsigned      PRESCALE = CLK_HZ / TICK_HZ;
    localparam int unsigned      PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             running_q, done_q;

    // The if/else chain encodes the per-cycle priority: load > stop > start > tick.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
            ps_d    = '0;
        end else if (stop) begin
            state_d = ST_STOPPED;
            ps_d    = '0;
        end else if (start && (state_q != ST_RUNNING)) begin
            state_d = ST_RUNNING;
            ps_d    = '0;
            if (state_q == ST_DONE) begin
                count_d = up_dn ? '0 : CNT_MAX;
            end
        end else if (state_q == ST_RUNNING) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                tick_d = 1'b1;
                if (up_dn) begin
                    if (count_q == CNT_MAX) begin
                        tc_d = 1'b1;
                        if (ONE_SHOT) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        tc_d = 1'b1;
                        if (ONE_SHOT) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = CNT_MAX;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_STOPPED;
            ps_q      <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            running_q <= (state_d == ST_RUNNING);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign tc      = tc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_led_tick_counter.sv
// Bench for led_tick_counter: three builds (free-run M10, one-shot M10,
// free-run M16), all at PRESCALE=8. Expected ticks carry the cycle number
// at which they must appear.
module tb_led_tick_counter;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  cnt;
        logic        tc;
    } exp_t;

    localparam int unsigned A = 5;
    localparam int unsigned B = 180;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    // DUT a: free-run, MODULUS=10
    logic       clr_a = 1'b1, start_a = 1'b0, stop_a = 1'b0, up_dn_a = 1'b1, load_a = 1'b0;
    logic [3:0] load_val_a = '0;
    logic [3:0] count_a;
    logic       tick_a, tc_a, running_a, done_a;

    // DUTs b (one-shot, MODULUS=10) and c (free-run, MODULUS=16) share stimulus
    logic       clr_bc = 1'b1, start_bc = 1'b0, stop_bc = 1'b0, up_dn_bc = 1'b1, load_bc = 1'b0;
    logic [3:0] load_val_bc = '0;
    logic [3:0] count_b, count_c;
    logic       tick_b, tc_b, running_b, done_b;
    logic       tick_c, tc_c, running_c, done_c;

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) u_a (
        .clk(clk), .clr(clr_a), .start(start_a), .stop(stop_a), .up_dn(up_dn_a),
        .load(load_a), .load_val(load_val_a), .count(count_a), .tick(tick_a),
        .tc(tc_a), .running(running_a), .done(done_a)
    );

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b1)) u_b (
        .clk(clk), .clr(clr_bc), .start(start_bc), .stop(stop_bc), .up_dn(up_dn_bc),
        .load(load_bc), .load_val(load_val_bc), .count(count_b), .tick(tick_b),
        .tc(tc_b), .running(running_b), .done(done_b)
    );

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(4), .MODULUS(16), .ONE_SHOT(1'b0)) u_c (
        .clk(clk), .clr(clr_bc), .start(start_bc), .stop(stop_bc), .up_dn(up_dn_bc),
        .load(load_bc), .load_val(load_val_bc), .count(count_c), .tick(tick_c),
        .tc(tc_c), .running(running_c), .done(done_c)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int which, input int unsigned c, input int n, input bit t);
        exp_t e;
        e.cyc = c;
        e.cnt = 4'(n);
        e.tc  = t;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic at_cyc(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every tick pops one expected entry; a tick with nothing pending is an error.
    always @(negedge clk) begin
        if (tc_a && !tick_a) begin
            n_err++;
            $display("FAIL a_tc_without_tick: cyc %0d", cyc);
        end
        if (tick_a) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_tick: cyc %0d count %0d tc %0d", cyc, count_a, tc_a);
            end else begin
                e_a = q_a.pop_front();
                if (e_a.cyc != cyc || e_a.cnt != count_a || e_a.tc != tc_a) begin
                    n_err++;
                    $display("FAIL a_tick: got cyc %0d count %0d tc %0d, expected cyc %0d count %0d tc %0d",
                             cyc, count_a, tc_a, e_a.cyc, e_a.cnt, e_a.tc);
                end
            end
        end
        if (tick_b) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_tick: cyc %0d count %0d tc %0d", cyc, count_b, tc_b);
            end else begin
                e_b = q_b.pop_front();
                if (e_b.cyc != cyc || e_b.cnt != count_b || e_b.tc != tc_b) begin
                    n_err++;
                    $display("FAIL b_tick: got cyc %0d count %0d tc %0d, expected cyc %0d count %0d tc %0d",
                             cyc, count_b, tc_b, e_b.cyc, e_b.cnt, e_b.tc);
                end
            end
        end
        if (tick_c) begin
            n_vec++;
            if (q_c.size() == 0) begin
                n_err++;
                $display("FAIL c_unexpected_tick: cyc %0d count %0d tc %0d", cyc, count_c, tc_c);
            end else begin
                e_c = q_c.pop_front();
                if (e_c.cyc != cyc || e_c.cnt != count_c || e_c.tc != tc_c) begin
                    n_err++;
                    $display("FAIL c_tick: got cyc %0d count %0d tc %0d, expected cyc %0d count %0d tc %0d",
                             cyc, count_c, tc_c, e_c.cyc, e_c.cnt, e_c.tc);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        at_cyc(2);
        chk("rst_count", int'(count_a), 0);
        chk("rst_tick", int'(tick_a), 0);
        chk("rst_tc", int'(tc_a), 0);
        chk("rst_running", int'(running_a), 0);
        chk("rst_done", int'(done_b), 0);
        at_cyc(3);
        clr_a  = 1'b0;
        clr_bc = 1'b0;

        // Up count with wrap: ticks every 8 clocks, tc only on 9->0
        at_cyc(A);
        up_dn_a = 1'b1;
        start_a = 1'b1;
        for (int k = 1; k <= 10; k++) push(0, A + 1 + 8 * k, k % 10, k == 10);
        at_cyc(A + 1);
        start_a = 1'b0;
        chk("start_running", int'(running_a), 1);
        chk("start_count", int'(count_a), 0);

        // Down from 0: 9 with tc, then 8 without
        at_cyc(A + 81);
        up_dn_a = 1'b0;
        push(0, A + 89, 9, 1'b1);
        push(0, A + 97, 8, 1'b0);

        // Load 13 coincident with a tick: clamped to 9, tick suppressed
        at_cyc(A + 104);
        load_a     = 1'b1;
        load_val_a = 4'd13;
        up_dn_a    = 1'b1;
        push(0, A + 113, 0, 1'b1);
        at_cyc(A + 105);
        load_a = 1'b0;
        chk("load_clamp", int'(count_a), 9);
        chk("load_no_tick", int'(tick_a), 0);
        chk("load_no_tc", int'(tc_a), 0);
        chk("load_running", int'(running_a), 1);

        // Stop mid-period, start+stop together, then start: full period again
        at_cyc(A + 115);
        stop_a = 1'b1;
        at_cyc(A + 116);
        stop_a = 1'b0;
        chk("stop_running", int'(running_a), 0);
        at_cyc(A + 118);
        start_a = 1'b1;
        stop_a  = 1'b1;
        at_cyc(A + 119);
        start_a = 1'b0;
        stop_a  = 1'b0;
        chk("startstop_running", int'(running_a), 0);
        at_cyc(A + 121);
        start_a = 1'b1;
        for (int k = 1; k <= 4; k++) push(0, A + 122 + 8 * k, k, 1'b0);
        at_cyc(A + 122);
        start_a = 1'b0;
        chk("restart_running", int'(running_a), 1);

        // Asynchronous clr while the count-5 tick is high
        at_cyc(A + 162);
        chk("pre_clr_count", int'(count_a), 5);
        chk("pre_clr_tick", int'(tick_a), 1);
        #1;
        clr_a = 1'b1;
        #1;
        chk("clr_count", int'(count_a), 0);
        chk("clr_tick", int'(tick_a), 0);
        chk("clr_tc", int'(tc_a), 0);
        chk("clr_running", int'(running_a), 0);
        at_cyc(A + 164);
        clr_a = 1'b0;

        // One-shot (b) and MODULUS=16 (c) started together
        at_cyc(B);
        up_dn_bc = 1'b1;
        start_bc = 1'b1;
        for (int k = 1; k <= 9; k++) push(1, B + 1 + 8 * k, k, 1'b0);
        push(1, B + 81, 9, 1'b1);
        for (int k = 1; k <= 16; k++) push(2, B + 1 + 8 * k, k % 16, k == 16);
        at_cyc(B + 1);
        start_bc = 1'b0;
        at_cyc(B + 81);
        chk("os_count_held", int'(count_b), 9);
        chk("os_done", int'(done_b), 1);
        chk("os_running", int'(running_b), 0);

        // Restart from DONE; start has no effect on the already running c
        at_cyc(B + 129);
        start_bc = 1'b1;
        push(2, B + 137, 1, 1'b0);
        push(1, B + 138, 1, 1'b0);
        at_cyc(B + 130);
        start_bc = 1'b0;
        chk("os_restart_count", int'(count_b), 0);
        chk("os_restart_running", int'(running_b), 1);
        chk("os_restart_done", int'(done_b), 0);
        chk("m16_running", int'(running_c), 1);

        at_cyc(B + 142);
        chk("a_pending", q_a.size(), 0);
        chk("b_pending", q_b.size(), 0);
        chk("c_pending", q_c.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
